charge_sweeper: RTL and testbench
=================================

// Module: charge_sweeper
// PURPOSE
//  Downstream consumer of the scatterer's charge grid. After a scatter pass it sweeps every
//  grid point in linear order, issues read requests on the scatterer's solve port, realigns the
//  fixed-latency charge responses and streams background-subtracted density to the field solver.
//  Valid/ready output with credit-based issue, so the non-stallable scatterer read path never overflows.
// PARAMETERS
//  GRID_POINTS  4096  total grid points, multiple of 8
//  RD_LATENCY   8     cycles from valid_req sampled high to charge_out valid (scatterer solve path)
//  FIFO_DEPTH   16    output FIFO entries (one entry = 8 samples); must be >= RD_LATENCY+2
// PORTS
//  clk            in   1            clock
//  rst_n          in   1            reset, asynchronous, active-low
//  start          in   1            pulse: begin a sweep (tie to scatterer done)
//  bg_charge      in   CWIDTH       neutralising background subtracted from every sample
//  valid_req      out  1            read request to scatterer
//  grid_addr_out  out  2x4 addr_t   [p][j] request addresses, port p lane j
//  charge_in      in   2x4 charge_t [p][j] scatterer charge_out, valid RD_LATENCY after request
//  rho_valid      out  1            output beat valid
//  rho_ready      in   1            solver accepts beat
//  rho_out        out  8 rho_t      density samples, lane i = grid point 8k+i
//  rho_last       out  1            marks final beat of the sweep
//  busy           out  1            high from accepted start until sweep_done
//  sweep_done     out  1            one-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset (async assert, sync deassert): FSM IDLE; valid_req, rho_valid, rho_last, busy, sweep_done = 0;
//   grid_addr_out, rho_out = 0; request index, in-flight count, FIFO pointers/count = 0.
//  FSM: IDLE -start-> SWEEP -last request issued-> DRAIN -last beat accepted-> DONE -> IDLE.
//   start ignored unless IDLE. DONE lasts one cycle, drives sweep_done=1; busy=0 only in IDLE.
//  Request k (0..GRID_POINTS/8-1): grid_addr_out[p][j] = 8k+4p+j; valid_req high one cycle per request,
//   registered output; back-to-back issue allowed (1 request/cycle max).
//  Credit rule: issue in cycle t only if fifo_count + inflight < FIFO_DEPTH, evaluated on
//   registered state; inflight = requests issued whose response not yet captured.
//  Alignment: RD_LATENCY-deep valid shift register plus shift of rho_last tag; when tap is high,
//   charge_in is captured, converted and pushed into FIFO the same cycle. No scatterer valid used.
//  Arithmetic: rho_t = signed CWIDTH+1; rho = $signed({1'b0,charge}) - $signed({1'b0,bg_charge}); exact,
//   no saturation. Lane order: rho_out[4p+j] <- charge_in[p][j].
//  FIFO: first-word-fall-through; rho_valid = !empty; pop on rho_valid && rho_ready.
//   Simultaneous push and pop when full is legal (count unchanged); credit rule guarantees push never
//   meets full without pop; overflow is an assertion failure.
//  rho_ready low indefinitely: issue stops once credits exhausted; in-flight responses still land.
//  Last request: tagged; rho_last high with its beat; DRAIN exits on that beat's handshake.
//  rst_n mid-sweep: all state cleared immediately; late scatterer responses ignored (shift reg cleared).
//  start during DONE cycle ignored.
// STRUCTURE
//  defs package: GRID_POINTS, SWEEP_LANES=8, RD_LATENCY, rho_t typedef; reuse addr_t, charge_t, CWIDTH.
//  Sub-module: sweep_fifo (sync FWFT FIFO, param WIDTH/DEPTH, count output, async active-low reset).
//  FSM, address counter, credit counter and latency shift register stay in charge_sweeper.
// TESTING
//  Bench models scatterer read path as an 8-cycle pipe returning charge = address value.
//  1 GRID_POINTS=64, rho_ready=1, bg=0, start -> 8 requests in 8 consecutive cycles, first beat 9 cycles
//    after first valid_req, rho_out[i]=8k+i, rho_last on beat 7, sweep_done 1 cycle later.
//  2 bg_charge=10, charge=3 at address 3 -> rho_out[3] = -7; charge=0x..max -> exact positive value.
//  3 rho_ready=0 for 100 cycles after start -> exactly FIFO_DEPTH requests issued, no overflow;
//    release ready -> remaining beats in order, no loss or duplication.
//  4 rho_ready toggling randomly 50% -> every address appears exactly once, in order; count = GRID_POINTS/8.
//  5 rst_n low at request 4 then start again -> no stale beats from first sweep, sequence restarts at 0.
//  6 start pulsed while busy and during DONE -> ignored; second start in IDLE runs a full sweep.

Source files
------------

// File: rtl/charge_sweeper_pkg.sv
// ============================================================================
// charge_sweeper_pkg : shared widths, types and defaults for the charge sweeper
// Revision 1.0
// ============================================================================
`default_nettype none

package charge_sweeper_pkg;

  localparam int GRID_POINTS    = 4096;
  localparam int SWEEP_LANES    = 8;
  localparam int RD_LATENCY     = 8;
  localparam int FIFO_DEPTH     = 16;
  localparam int CWIDTH         = 16;
  localparam int AWIDTH         = 12;
  localparam int PORTS          = 2;
  localparam int LANES_PER_PORT = 4;

  typedef logic [AWIDTH-1:0]        addr_t;
  typedef logic [CWIDTH-1:0]        charge_t;
  typedef logic signed [CWIDTH:0]   rho_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sweep_state_e;

  // Both operands are unsigned magnitudes; one extra bit keeps the difference exact.
  function automatic rho_t to_rho(input charge_t charge, input charge_t bg);
    return $signed({1'b0, charge}) - $signed({1'b0, bg});
  endfunction

endpackage

`default_nettype wire

// File: rtl/sweep_fifo.sv
// ============================================================================
// sweep_fifo : synchronous first-word-fall-through FIFO with occupancy count
// Revision 1.0
// ============================================================================
`default_nettype none

module sweep_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full && !do_pop));

endmodule

`default_nettype wire

// File: rtl/charge_sweeper.sv
// ============================================================================
// charge_sweeper : sweeps the scatterer charge grid, realigns fixed-latency
//                  reads and streams background-subtracted density beats
// Revision 1.0
// ============================================================================
`default_nettype none

module charge_sweeper
  import charge_sweeper_pkg::*;
#(
  parameter int GRID_POINTS = charge_sweeper_pkg::GRID_POINTS,
  parameter int RD_LATENCY  = charge_sweeper_pkg::RD_LATENCY,
  parameter int FIFO_DEPTH  = charge_sweeper_pkg::FIFO_DEPTH
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  charge_t                                  bg_charge,
  output logic                                     valid_req,
  output addr_t   [PORTS-1:0][LANES_PER_PORT-1:0]  grid_addr_out,
  input  charge_t [PORTS-1:0][LANES_PER_PORT-1:0]  charge_in,
  output logic                                     rho_valid,
  input  logic                                     rho_ready,
  output rho_t    [SWEEP_LANES-1:0]                rho_out,
  output logic                                     rho_last,
  output logic                                     busy,
  output logic                                     sweep_done
);

  localparam int NREQ   = GRID_POINTS / SWEEP_LANES;
  localparam int IDXW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW   = $clog2(FIFO_DEPTH+1);
  localparam int FIFO_W = SWEEP_LANES * $bits(rho_t);

  sweep_state_e state_q, state_d;
  logic [IDXW-1:0]       req_idx_q, req_idx_d;
  logic [CNTW-1:0]       inflight_q, inflight_d;
  addr_t [PORTS-1:0][LANES_PER_PORT-1:0] addr_q, addr_d;
  logic                  valid_req_q;
  logic                  last_req_q;
  logic [RD_LATENCY-1:0] vld_sr_q;
  logic [RD_LATENCY-1:0] last_sr_q;

  logic                  issue;
  logic                  issue_last;
  logic                  credit_ok;
  logic                  tap_vld;
  logic                  tap_last;
  logic                  pop;
  logic                  fifo_empty;
  logic [CNTW-1:0]       fifo_count;
  logic [FIFO_W:0]       fifo_rdata;
  logic [FIFO_W:0]       push_data;
  rho_t [SWEEP_LANES-1:0] conv;

  assign tap_vld  = vld_sr_q[RD_LATENCY-1];
  assign tap_last = last_sr_q[RD_LATENCY-1];

  always_comb begin
    state_d    = state_q;
    req_idx_d  = req_idx_q;
    addr_d     = addr_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    // Responses still in flight already own a FIFO slot.
    credit_ok  = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SWEEP;
          req_idx_d = '0;
        end
      end
      S_SWEEP: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (req_idx_q == IDXW'(NREQ-1));
          req_idx_d  = req_idx_q + 1'b1;
          for (int p = 0; p < PORTS; p++) begin
            for (int j = 0; j < LANES_PER_PORT; j++) begin
              addr_d[p][j] = AWIDTH'({req_idx_q, 3'(LANES_PER_PORT*p + j)});
            end
          end
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && fifo_rdata[FIFO_W]) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign inflight_d = inflight_q + CNTW'(issue) - CNTW'(tap_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_idx_q   <= '0;
      inflight_q  <= '0;
      addr_q      <= '0;
      valid_req_q <= 1'b0;
      last_req_q  <= 1'b0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_idx_q   <= req_idx_d;
      inflight_q  <= inflight_d;
      addr_q      <= addr_d;
      valid_req_q <= issue;
      last_req_q  <= issue_last;
      vld_sr_q    <= {vld_sr_q[RD_LATENCY-2:0], valid_req_q};
      last_sr_q   <= {last_sr_q[RD_LATENCY-2:0], last_req_q};
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    for (genvar j = 0; j < LANES_PER_PORT; j++) begin : g_lane
      assign conv[LANES_PER_PORT*p + j] = to_rho(charge_in[p][j], bg_charge);
    end
  end

  assign push_data = {tap_last, conv};

  sweep_fifo #(
    .WIDTH (FIFO_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tap_vld),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rho_valid     = !fifo_empty;
  assign pop           = rho_valid && rho_ready;
  // The FIFO storage is not reset, so the head is masked while empty.
  assign rho_out       = rho_valid ? fifo_rdata[FIFO_W-1:0] : '0;
  assign rho_last      = rho_valid && fifo_rdata[FIFO_W];
  assign valid_req     = valid_req_q;
  assign grid_addr_out = addr_q;
  assign busy          = (state_q != S_IDLE);
  assign sweep_done    = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_charge_sweeper.sv
// ============================================================================
// tb_charge_sweeper : directed bench with an 8-cycle scatterer read-path model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_charge_sweeper;
  import charge_sweeper_pkg::*;

  localparam int GP    = 256;
  localparam int NREQ  = GP / SWEEP_LANES;
  localparam int LAT   = RD_LATENCY;
  localparam int DEPTH = FIFO_DEPTH;

  logic    clk       = 1'b0;
  logic    rst_n     = 1'b0;
  logic    start     = 1'b0;
  logic    rho_ready = 1'b0;
  charge_t bg_charge = '0;
  logic    valid_req;
  addr_t   [PORTS-1:0][LANES_PER_PORT-1:0] grid_addr_out;
  charge_t [PORTS-1:0][LANES_PER_PORT-1:0] charge_in;
  logic    rho_valid, rho_last, busy, sweep_done;
  rho_t    [SWEEP_LANES-1:0] rho_out;

  always #5 clk = ~clk;

  charge_sweeper #(
    .GRID_POINTS (GP),
    .RD_LATENCY  (LAT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .bg_charge     (bg_charge),
    .valid_req     (valid_req),
    .grid_addr_out (grid_addr_out),
    .charge_in     (charge_in),
    .rho_valid     (rho_valid),
    .rho_ready     (rho_ready),
    .rho_out       (rho_out),
    .rho_last      (rho_last),
    .busy          (busy),
    .sweep_done    (sweep_done)
  );

  // Scatterer charge: the address itself, except the top grid point reads full scale.
  function automatic charge_t exp_charge(input addr_t a);
    return (int'(a) == GP-1) ? '1 : charge_t'(a);
  endfunction

  logic [LAT-1:0] pv = '0;
  addr_t [PORTS-1:0][LANES_PER_PORT-1:0] pa [LAT];

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], valid_req};
    pa[0] <= grid_addr_out;
    for (int s = 1; s < LAT; s++) pa[s] <= pa[s-1];
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++)
      for (int j = 0; j < LANES_PER_PORT; j++)
        charge_in[p][j] = pv[LAT-1] ? exp_charge(pa[LAT-1][p][j]) : charge_t'(16'hBEEF);
  end

  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc      = 0;
  int     req_cnt, beat_cnt, done_cnt;
  int     first_req_cyc, last_req_cyc, first_beat_cyc, last_beat_cyc, done_cyc;
  longint cap_b0l3, cap_last_l7;
  bit     saw_last      = 1'b0;
  bit     rand_ready    = 1'b0;
  bit     start_on_last = 1'b0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic new_sweep();
    req_cnt = 0; beat_cnt = 0; done_cnt = 0;
    first_req_cyc = -1; last_req_cyc = -1;
    first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
  endtask

  task automatic observe();
    if (valid_req) begin
      if (req_cnt == 0) first_req_cyc = cyc;
      last_req_cyc = cyc;
      for (int p = 0; p < PORTS; p++)
        for (int j = 0; j < LANES_PER_PORT; j++)
          check("req_addr", longint'(grid_addr_out[p][j]), longint'(8*req_cnt + 4*p + j));
      req_cnt++;
    end
    saw_last = 1'b0;
    if (rho_valid && rho_ready) begin
      if (beat_cnt == 0) begin
        first_beat_cyc = cyc;
        cap_b0l3 = longint'($signed(rho_out[3]));
      end
      if (beat_cnt == NREQ-1) cap_last_l7 = longint'($signed(rho_out[7]));
      for (int i = 0; i < SWEEP_LANES; i++)
        check("rho_lane", longint'($signed(rho_out[i])),
              longint'(exp_charge(addr_t'(8*beat_cnt + i))) - longint'(bg_charge));
      check("rho_last", longint'(rho_last), longint'(beat_cnt == NREQ-1));
      last_beat_cyc = cyc;
      saw_last = rho_last;
      beat_cnt++;
    end
    if (sweep_done) begin
      done_cyc = cyc;
      done_cnt++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    if (start_on_last) start = saw_last;
    if (rand_ready) rho_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    check("sweep_done_seen", done_cnt, 1);
  endtask

  task automatic wait_reqs(input int target, input int budget);
    int n = 0;
    while (req_cnt < target && n < budget) begin
      step();
      n++;
    end
    check("req_reached", req_cnt, target);
  endtask

  initial begin
    new_sweep();
    step();
    step();
    check("rst_valid_req", valid_req, 0);
    check("rst_rho_valid", rho_valid, 0);
    check("rst_rho_last", rho_last, 0);
    check("rst_busy", busy, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_addr", longint'(|grid_addr_out), 0);
    check("rst_rho_out", longint'(|rho_out), 0);
    rst_n = 1'b1;
    step();

    // Free-flowing sweep: timing and ordering.
    rho_ready = 1'b1;
    bg_charge = '0;
    new_sweep();
    pulse_start();
    check("busy_after_start", busy, 1);
    wait_done(400);
    check("t1_reqs", req_cnt, NREQ);
    check("t1_beats", beat_cnt, NREQ);
    check("t1_req_back2back", last_req_cyc - first_req_cyc, NREQ-1);
    check("t1_first_beat_lat", first_beat_cyc - first_req_cyc, 9);
    check("t1_done_after_last", done_cyc - last_beat_cyc, 1);
    step();
    check("t1_idle_busy", busy, 0);

    // Background subtraction, negative and full-scale results.
    bg_charge = charge_t'(10);
    new_sweep();
    pulse_start();
    wait_done(400);
    check("t2_beats", beat_cnt, NREQ);
    check("t2_addr3_rho", cap_b0l3, -7);
    check("t2_max_rho", cap_last_l7, 65525);
    bg_charge = '0;

    // Consumer stalled: issue stops at the credit limit.
    rho_ready = 1'b0;
    new_sweep();
    pulse_start();
    repeat (100) step();
    check("t3_stall_reqs", req_cnt, DEPTH);
    check("t3_stall_beats", beat_cnt, 0);
    check("t3_stall_valid", rho_valid, 1);
    check("t3_stall_busy", busy, 1);
    rho_ready = 1'b1;
    wait_done(400);
    check("t3_reqs", req_cnt, NREQ);
    check("t3_beats", beat_cnt, NREQ);

    // Random back-pressure.
    rand_ready = 1'b1;
    new_sweep();
    pulse_start();
    wait_done(2000);
    rand_ready = 1'b0;
    rho_ready  = 1'b1;
    check("t4_reqs", req_cnt, NREQ);
    check("t4_beats", beat_cnt, NREQ);

    // Reset in the middle of a sweep; late responses must be dropped.
    new_sweep();
    pulse_start();
    wait_reqs(4, 50);
    rst_n = 1'b0;
    step();
    step();
    check("t5_rst_valid_req", valid_req, 0);
    check("t5_rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (15) step();
    check("t5_no_stale_beats", beat_cnt, 0);
    check("t5_no_stale_valid", rho_valid, 0);
    new_sweep();
    pulse_start();
    wait_done(400);
    check("t5_reqs", req_cnt, NREQ);
    check("t5_beats", beat_cnt, NREQ);

    // Start while busy and during DONE is ignored.
    new_sweep();
    pulse_start();
    wait_reqs(10, 50);
    pulse_start();
    start_on_last = 1'b1;
    wait_done(400);
    start_on_last = 1'b0;
    start = 1'b0;
    check("t6_reqs", req_cnt, NREQ);
    check("t6_beats", beat_cnt, NREQ);
    repeat (30) step();
    check("t6_no_restart_reqs", req_cnt, NREQ);
    check("t6_idle_busy", busy, 0);
    check("t6_single_done", done_cnt, 1);
    new_sweep();
    pulse_start();
    wait_done(400);
    check("t6_second_reqs", req_cnt, NREQ);
    check("t6_second_beats", beat_cnt, NREQ);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
